ecc_dec_arbiter: RTL

//  Shares one 72->64 SECDED decode datapath (stage-1 syndrome/ERRr + stage-2 correction) between two requesters.

---
 rtl/ecc_dec_arbiter.sv | 122 ++++++++++++
 1 files changed

// File: rtl/ecc_dec_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ecc_dec_arbiter
// Purpose  : Round-robin share of one external SECDED decoder between two
//            requesters, with a valid/ready response port and an error counter.
// Revision : 1.0  initial release
// ============================================================================
module ecc_dec_arbiter #(
    parameter int DEC_LAT = 1,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [71:0]      req0_code,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [71:0]      req1_code,
    output logic             req1_ready,
    output logic [71:0]      dec_in,
    input  logic [63:0]      dec_data,
    input  logic             dec_err,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [63:0]      rsp_data,
    output logic             rsp_err,
    output logic [CNT_W-1:0] err_cnt,
    input  logic             err_cnt_clr
);

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_wait   = 2'd1;
    localparam logic [1:0] c_st_resp   = 2'd2;
    localparam logic [1:0] c_wait_init = 2'(DEC_LAT - 1);

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic             r_last_grant;
    logic [1:0]       r_wait_cnt;
    logic [71:0]      r_dec_in;
    logic             r_rsp_id;
    logic [63:0]      r_rsp_data;
    logic             r_rsp_err;
    logic [CNT_W-1:0] r_err_cnt;
    logic             w_grant0;
    logic             w_grant1;
    logic             w_accept;
    logic             w_capture;

    // On a tie the requester that did not win last time is served.
    always_comb begin
        w_grant0 = req0_valid & (~req1_valid | r_last_grant);
        w_grant1 = req1_valid & (~req0_valid | ~r_last_grant);
    end

    assign req0_ready = (r_state == c_st_idle) & ~rst & w_grant0;
    assign req1_ready = (r_state == c_st_idle) & ~rst & w_grant1;
    assign w_accept   = req0_ready | req1_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (w_accept) w_state_nxt = c_st_wait;
            end
            c_st_wait: begin
                if (r_wait_cnt == 2'd0) begin
                    w_capture   = 1'b1;
                    w_state_nxt = c_st_resp;
                end
            end
            c_st_resp: begin
                if (rsp_ready) w_state_nxt = c_st_idle;
            end
            default: w_state_nxt = c_st_idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_st_idle;
            r_last_grant <= 1'b1;
            r_wait_cnt   <= 2'd0;
            r_dec_in     <= '0;
            r_rsp_id     <= 1'b0;
            r_rsp_data   <= '0;
            r_rsp_err    <= 1'b0;
            r_err_cnt    <= '0;
        end else begin
            r_state <= w_state_nxt;
            // dec_in only moves on accept so the decoder sees a stable word.
            if (w_accept) begin
                r_dec_in     <= req1_ready ? req1_code : req0_code;
                r_rsp_id     <= req1_ready;
                r_last_grant <= req1_ready;
                r_wait_cnt   <= c_wait_init;
            end else if ((r_state == c_st_wait) && (r_wait_cnt != 2'd0)) begin
                r_wait_cnt <= r_wait_cnt - 2'd1;
            end
            if (w_capture) begin
                r_rsp_data <= dec_data;
                r_rsp_err  <= dec_err;
            end
            if (err_cnt_clr) begin
                r_err_cnt <= '0;
            end else if (w_capture && dec_err && !(&r_err_cnt)) begin
                r_err_cnt <= r_err_cnt + 1'b1;
            end
        end
    end

    assign dec_in    = r_dec_in;
    assign rsp_valid = (r_state == c_st_resp);
    assign rsp_id    = r_rsp_id;
    assign rsp_data  = r_rsp_data;
    assign rsp_err   = r_rsp_err;
    assign err_cnt   = r_err_cnt;

endmodule
`default_nettype wire
